// File: rtl/flash_arb.sv
// Two-port lock arbiter in front of the flash controller command interface.
// A granted port keeps the controller for a whole command sequence; owners alternate round-robin.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no owner, arbitrate pending requests (rr_ptr breaks ties)
// GRANT0   | port 0 owns the controller
// GRANT1   | port 1 owns the controller
// RELEASE  | one dead cycle, round-robin pointer moves to the other port
module flash_arb (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        req1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        err0,
   output logic        err1,
   input  logic        s0_wr_en,
   input  logic [24:0] s0_wr_addr,
   input  logic [15:0] s0_wr_data,
   output logic        s0_wr_done,
   input  logic        s0_rd_en,
   input  logic [24:0] s0_rd_addr,
   input  logic [16:0] s0_rd_length,
   output logic [15:0] s0_rd_data,
   output logic        s0_rd_valid,
   output logic        s0_rd_done,
   input  logic        s1_wr_en,
   input  logic [24:0] s1_wr_addr,
   input  logic [15:0] s1_wr_data,
   output logic        s1_wr_done,
   input  logic        s1_rd_en,
   input  logic [24:0] s1_rd_addr,
   input  logic [16:0] s1_rd_length,
   output logic [15:0] s1_rd_data,
   output logic        s1_rd_valid,
   output logic        s1_rd_done,
   output logic        m_wr_en,
   output logic [24:0] m_wr_addr,
   output logic [15:0] m_wr_data,
   input  logic        m_wr_done,
   output logic        m_rd_en,
   output logic [24:0] m_rd_addr,
   output logic [16:0] m_rd_length,
   input  logic [15:0] m_rd_data,
   input  logic        m_rd_valid,
   input  logic        m_rd_done
);

   typedef enum logic [3:0] {
      ST_IDLE    = 4'b0001,
      ST_GRANT0  = 4'b0010,
      ST_GRANT1  = 4'b0100,
      ST_RELEASE = 4'b1000
   } state_t;

   state_t state;
   state_t state_nxt;
   logic   busy;
   logic   rr_ptr;
   logic   owner;

   logic cmd0, cmd1;
   logic acc0, acc1;
   logic wr_acc0, wr_acc1, rd_acc0, rd_acc1;
   logic done_in;

   assign cmd0    = s0_wr_en | s0_rd_en;
   assign cmd1    = s1_wr_en | s1_rd_en;
   assign acc0    = (state == ST_GRANT0) & ~busy & (s0_wr_en ^ s0_rd_en);
   assign acc1    = (state == ST_GRANT1) & ~busy & (s1_wr_en ^ s1_rd_en);
   assign wr_acc0 = acc0 & s0_wr_en;
   assign rd_acc0 = acc0 & s0_rd_en;
   assign wr_acc1 = acc1 & s1_wr_en;
   assign rd_acc1 = acc1 & s1_rd_en;
   assign done_in = m_wr_done | m_rd_done;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // A done arriving this cycle counts as not busy so release lands one cycle after it.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (req0 && req1) begin
               state_nxt = rr_ptr ? ST_GRANT1 : ST_GRANT0;
            end else if (req0) begin
               state_nxt = ST_GRANT0;
            end else if (req1) begin
               state_nxt = ST_GRANT1;
            end
         end
         ST_GRANT0: begin
            if (!req0 && (!busy || done_in) && !cmd0) begin
               state_nxt = ST_RELEASE;
            end
         end
         ST_GRANT1: begin
            if (!req1 && (!busy || done_in) && !cmd1) begin
               state_nxt = ST_RELEASE;
            end
         end
         ST_RELEASE: state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      gnt0 = (state == ST_GRANT0);
      gnt1 = (state == ST_GRANT1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy   <= 1'b0;
         rr_ptr <= 1'b0;
         owner  <= 1'b0;
      end else begin
         if (acc0 || acc1) begin
            busy <= 1'b1;
         end else if (done_in) begin
            busy <= 1'b0;
         end
         if (state == ST_GRANT0) begin
            owner <= 1'b0;
         end else if (state == ST_GRANT1) begin
            owner <= 1'b1;
         end
         if (state == ST_RELEASE) begin
            rr_ptr <= ~owner;
         end
      end
   end

   // Command path: one-cycle pulse, payload zero whenever nothing is forwarded.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_wr_en     <= 1'b0;
         m_wr_addr   <= '0;
         m_wr_data   <= '0;
         m_rd_en     <= 1'b0;
         m_rd_addr   <= '0;
         m_rd_length <= '0;
         err0        <= 1'b0;
         err1        <= 1'b0;
      end else begin
         m_wr_en     <= wr_acc0 | wr_acc1;
         m_wr_addr   <= wr_acc0 ? s0_wr_addr : (wr_acc1 ? s1_wr_addr : '0);
         m_wr_data   <= wr_acc0 ? s0_wr_data : (wr_acc1 ? s1_wr_data : '0);
         m_rd_en     <= rd_acc0 | rd_acc1;
         m_rd_addr   <= rd_acc0 ? s0_rd_addr : (rd_acc1 ? s1_rd_addr : '0);
         m_rd_length <= rd_acc0 ? s0_rd_length : (rd_acc1 ? s1_rd_length : '0);
         err0        <= cmd0 & ~acc0;
         err1        <= cmd1 & ~acc1;
      end
   end

   // Response path: routed by the grant held when the response arrives.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s0_wr_done  <= 1'b0;
         s0_rd_data  <= '0;
         s0_rd_valid <= 1'b0;
         s0_rd_done  <= 1'b0;
         s1_wr_done  <= 1'b0;
         s1_rd_data  <= '0;
         s1_rd_valid <= 1'b0;
         s1_rd_done  <= 1'b0;
      end else begin
         s0_wr_done  <= gnt0 & m_wr_done;
         s0_rd_data  <= gnt0 ? m_rd_data : '0;
         s0_rd_valid <= gnt0 & m_rd_valid;
         s0_rd_done  <= gnt0 & m_rd_done;
         s1_wr_done  <= gnt1 & m_wr_done;
         s1_rd_data  <= gnt1 ? m_rd_data : '0;
         s1_rd_valid <= gnt1 & m_rd_valid;
         s1_rd_done  <= gnt1 & m_rd_done;
      end
   end

endmodule

// File: tb/tb_flash_arb.sv
// Scoreboard bench for flash_arb: stimulus pushes expected commands, responses and
// error pulses into queues; a negedge monitor pops and compares whatever the DUT shows.
module tb_flash_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0, req1;
   logic        gnt0, gnt1, err0, err1;
   logic        s0_wr_en, s0_rd_en, s1_wr_en, s1_rd_en;
   logic [24:0] s0_wr_addr, s0_rd_addr, s1_wr_addr, s1_rd_addr;
   logic [15:0] s0_wr_data, s1_wr_data;
   logic [16:0] s0_rd_length, s1_rd_length;
   logic        s0_wr_done, s0_rd_valid, s0_rd_done;
   logic        s1_wr_done, s1_rd_valid, s1_rd_done;
   logic [15:0] s0_rd_data, s1_rd_data;
   logic        m_wr_en, m_rd_en;
   logic [24:0] m_wr_addr, m_rd_addr;
   logic [15:0] m_wr_data;
   logic [16:0] m_rd_length;
   logic        m_wr_done, m_rd_valid, m_rd_done;
   logic [15:0] m_rd_data;

   logic [126:0] all_out;
   assign all_out = {gnt0, gnt1, err0, err1,
                     s0_wr_done, s0_rd_data, s0_rd_valid, s0_rd_done,
                     s1_wr_done, s1_rd_data, s1_rd_valid, s1_rd_done,
                     m_wr_en, m_wr_addr, m_wr_data, m_rd_en, m_rd_addr, m_rd_length};

   flash_arb dut (
      .clk(clk), .rst(rst), .req0(req0), .req1(req1),
      .gnt0(gnt0), .gnt1(gnt1), .err0(err0), .err1(err1),
      .s0_wr_en(s0_wr_en), .s0_wr_addr(s0_wr_addr), .s0_wr_data(s0_wr_data), .s0_wr_done(s0_wr_done),
      .s0_rd_en(s0_rd_en), .s0_rd_addr(s0_rd_addr), .s0_rd_length(s0_rd_length),
      .s0_rd_data(s0_rd_data), .s0_rd_valid(s0_rd_valid), .s0_rd_done(s0_rd_done),
      .s1_wr_en(s1_wr_en), .s1_wr_addr(s1_wr_addr), .s1_wr_data(s1_wr_data), .s1_wr_done(s1_wr_done),
      .s1_rd_en(s1_rd_en), .s1_rd_addr(s1_rd_addr), .s1_rd_length(s1_rd_length),
      .s1_rd_data(s1_rd_data), .s1_rd_valid(s1_rd_valid), .s1_rd_done(s1_rd_done),
      .m_wr_en(m_wr_en), .m_wr_addr(m_wr_addr), .m_wr_data(m_wr_data), .m_wr_done(m_wr_done),
      .m_rd_en(m_rd_en), .m_rd_addr(m_rd_addr), .m_rd_length(m_rd_length),
      .m_rd_data(m_rd_data), .m_rd_valid(m_rd_valid), .m_rd_done(m_rd_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        kind;
      logic [24:0] addr;
      logic [16:0] val;
   } cmd_t;

   typedef struct packed {
      logic        p;
      logic [1:0]  kind;
      logic [15:0] data;
   } rsp_t;

   cmd_t cmd_q[$];
   rsp_t rsp_q[$];
   int   err_q[$];
   int   nvec = 0;
   int   nfail = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nfail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_zero(input string name);
      nvec++;
      if (all_out !== '0) begin
         nfail++;
         $display("FAIL %s: outputs %0h, expected all zero", name, all_out);
      end
   endtask

   function automatic logic [15:0] beat(input int p, input int i);
      return 16'(32'h5A00 + p * 256 + i);
   endfunction

   function automatic int gnt_of(input int p);
      return (p != 0) ? int'(gnt1) : int'(gnt0);
   endfunction

   task automatic set_req(input int p, input logic v);
      if (p != 0) req1 = v;
      else        req0 = v;
   endtask

   task automatic clear_cmds();
      s0_wr_en = 0; s0_rd_en = 0; s0_wr_addr = '0; s0_wr_data = '0; s0_rd_addr = '0; s0_rd_length = '0;
      s1_wr_en = 0; s1_rd_en = 0; s1_wr_addr = '0; s1_wr_data = '0; s1_rd_addr = '0; s1_rd_length = '0;
   endtask

   task automatic drive_cmd(input int p, input logic wr, input logic rd,
                            input logic [24:0] a, input logic [16:0] v);
      if (p == 0) begin
         s0_wr_en = wr; s0_rd_en = rd; s0_wr_addr = a; s0_wr_data = v[15:0];
         s0_rd_addr = a; s0_rd_length = v;
      end else begin
         s1_wr_en = wr; s1_rd_en = rd; s1_wr_addr = a; s1_wr_data = v[15:0];
         s1_rd_addr = a; s1_rd_length = v;
      end
      tick();
      clear_cmds();
   endtask

   task automatic issue(input int p, input logic kind, input logic [24:0] a, input logic [16:0] v);
      cmd_t e;
      e.kind = kind;
      e.addr = a;
      e.val  = kind ? v : {1'b0, v[15:0]};
      cmd_q.push_back(e);
      drive_cmd(p, ~kind, kind, a, v);
   endtask

   task automatic violate(input int p, input logic wr, input logic rd, input logic [24:0] a, input logic [16:0] v);
      err_q.push_back(p);
      drive_cmd(p, wr, rd, a, v);
      chk("viol_no_forward", int'(m_wr_en | m_rd_en), 0);
   endtask

   task automatic gap();
      tick();
      chk("m_idle_payload", int'(m_wr_en | m_rd_en | (|m_wr_addr) | (|m_wr_data) | (|m_rd_addr) | (|m_rd_length)), 0);
   endtask

   task automatic push_rsp(input int p, input logic [1:0] kind, input logic [15:0] d);
      rsp_t e;
      e.p = 1'(p);
      e.kind = kind;
      e.data = d;
      rsp_q.push_back(e);
   endtask

   task automatic flash_wr(input int p, input logic drop);
      gap();
      m_wr_done = 1;
      if (drop) set_req(p, 0);
      push_rsp(p, 2'd0, 16'h0);
      tick();
      m_wr_done = 0;
   endtask

   task automatic flash_rd(input int p, input int len, input logic drop, input logic hold_chk);
      gap();
      for (int i = 0; i < len; i++) begin
         m_rd_valid = 1;
         m_rd_data  = beat(p, i);
         push_rsp(p, 2'd1, beat(p, i));
         tick();
         chk("nonowner_rd_data", (p != 0) ? int'(s0_rd_data) : int'(s1_rd_data), 0);
         if (hold_chk) chk("gnt_held_burst", gnt_of(p), 1);
      end
      m_rd_valid = 0;
      m_rd_data  = '0;
      m_rd_done  = 1;
      if (drop) set_req(p, 0);
      push_rsp(p, 2'd2, 16'h0);
      tick();
      m_rd_done = 0;
   endtask

   task automatic apply_reset();
      rst = 1;
      req0 = 0; req1 = 0;
      clear_cmds();
      m_wr_done = 0; m_rd_valid = 0; m_rd_done = 0; m_rd_data = '0;
      tick();
      chk_zero("reset_state");
      tick();
      rst = 0;
   endtask

   task automatic mon_cmd(input logic kind, input logic [24:0] a, input logic [16:0] v);
      cmd_t e;
      nvec++;
      if (cmd_q.size() == 0) begin
         nfail++;
         $display("FAIL cmd_unexpected: got kind %0d addr %0h val %0h, expected none", kind, a, v);
      end else begin
         e = cmd_q.pop_front();
         if (e.kind !== kind || e.addr !== a || e.val !== v) begin
            nfail++;
            $display("FAIL cmd_fwd: got kind %0d addr %0h val %0h, expected kind %0d addr %0h val %0h",
                     kind, a, v, e.kind, e.addr, e.val);
         end
      end
   endtask

   task automatic mon_rsp(input logic p, input logic [1:0] kind, input logic [15:0] d);
      rsp_t e;
      nvec++;
      if (rsp_q.size() == 0) begin
         nfail++;
         $display("FAIL rsp_unexpected: got port %0d kind %0d data %0h, expected none", p, kind, d);
      end else begin
         e = rsp_q.pop_front();
         if (e.p !== p || e.kind !== kind || (kind == 2'd1 && e.data !== d)) begin
            nfail++;
            $display("FAIL rsp_route: got port %0d kind %0d data %0h, expected port %0d kind %0d data %0h",
                     p, kind, d, e.p, e.kind, e.data);
         end
      end
   endtask

   task automatic mon_err(input int p);
      int e;
      nvec++;
      if (err_q.size() == 0) begin
         nfail++;
         $display("FAIL err_unexpected: got err%0d, expected none", p);
      end else begin
         e = err_q.pop_front();
         if (e != p) begin
            nfail++;
            $display("FAIL err_port: got err%0d, expected err%0d", p, e);
         end
      end
   endtask

   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (m_wr_en) mon_cmd(1'b0, m_wr_addr, {1'b0, m_wr_data});
         if (m_rd_en) mon_cmd(1'b1, m_rd_addr, m_rd_length);
         if (s0_wr_done)  mon_rsp(1'b0, 2'd0, 16'h0);
         if (s0_rd_valid) mon_rsp(1'b0, 2'd1, s0_rd_data);
         if (s0_rd_done)  mon_rsp(1'b0, 2'd2, 16'h0);
         if (s1_wr_done)  mon_rsp(1'b1, 2'd0, 16'h0);
         if (s1_rd_valid) mon_rsp(1'b1, 2'd1, s1_rd_data);
         if (s1_rd_done)  mon_rsp(1'b1, 2'd2, 16'h0);
         if (err0) mon_err(0);
         if (err1) mon_err(1);
         if (gnt0 || gnt1) begin
            nvec++;
            if (gnt0 && gnt1) begin
               nfail++;
               $display("FAIL gnt_exclusive: got gnt0=1 gnt1=1, expected at most one");
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, expected finish");
      $fatal(1);
   end

   initial begin
      int p;
      int c;
      rst = 0;
      req0 = 0; req1 = 0;
      clear_cmds();
      m_wr_done = 0; m_rd_valid = 0; m_rd_done = 0; m_rd_data = '0;
      #1 rst = 1;

      // single requester sequence
      apply_reset();
      req0 = 1;
      tick();
      chk("t1_gnt0", int'(gnt0), 1);
      chk("t1_gnt1", int'(gnt1), 0);
      issue(0, 1'b0, 25'h6407, 17'h0060);  flash_wr(0, 1'b0);
      issue(0, 1'b0, 25'h6407, 17'h0003);  flash_wr(0, 1'b0);
      issue(0, 1'b1, 25'h12345, 17'd4);    flash_rd(0, 4, 1'b0, 1'b0);
      issue(0, 1'b0, 25'h8000, 17'h0060);  flash_wr(0, 1'b0);
      issue(0, 1'b0, 25'h8000, 17'h0003);  flash_wr(0, 1'b0);
      chk("t1_gnt0_held", int'(gnt0), 1);
      req0 = 0;
      tick();
      chk("t1_release", int'(gnt0), 0);
      tick();
      chk("t1_idle", int'(gnt0 | gnt1), 0);

      // contention: port 0 wins first, port 1 three cycles after the final done
      apply_reset();
      req0 = 1; req1 = 1;
      tick();
      chk("t2_gnt0_first", int'(gnt0), 1);
      chk("t2_gnt1_wait", int'(gnt1), 0);
      issue(0, 1'b0, 25'h0100, 17'h1234);
      flash_wr(0, 1'b1);
      chk("t2_k1_dead", int'(gnt0 | gnt1), 0);
      tick();
      chk("t2_k2_dead", int'(gnt0 | gnt1), 0);
      tick();
      chk("t2_k3_gnt1", int'(gnt1), 1);
      issue(1, 1'b1, 25'h2000, 17'd2);
      flash_rd(1, 2, 1'b1, 1'b0);
      tick(); tick();

      // round-robin with both requesters always pending
      apply_reset();
      req0 = 1; req1 = 1;
      for (int i = 0; i < 6; i++) begin
         c = 0;
         while (!(gnt0 || gnt1) && c < 10) begin
            tick();
            c++;
         end
         chk("rr_gnt_wait", int'(c < 10), 1);
         p = gnt1 ? 1 : 0;
         chk("rr_order", p, i % 2);
         issue(p, 1'b0, 25'(32'h300 + i), 17'(i));
         flash_wr(p, 1'b1);
         set_req(p, 1'b1);
      end
      req0 = 0; req1 = 0;
      tick(); tick(); tick();

      // protocol violations
      apply_reset();
      req0 = 1;
      tick();
      violate(1, 1'b0, 1'b1, 25'h0055, 17'd8);
      chk("v1_gnt0_kept", int'(gnt0), 1);
      chk("v1_gnt1_low", int'(gnt1), 0);
      issue(0, 1'b1, 25'h0777, 17'd3);
      violate(0, 1'b1, 1'b0, 25'h0999, 17'h0abc);
      flash_rd(0, 3, 1'b0, 1'b0);
      violate(0, 1'b1, 1'b1, 25'h0444, 17'h0011);
      chk("v3_gnt0_kept", int'(gnt0), 1);
      req0 = 0;
      issue(0, 1'b0, 25'h8000, 17'h0003);
      chk("v4_cmd_with_req_fall", int'(gnt0), 1);
      flash_wr(0, 1'b0);
      chk("v4_release_after_done", int'(gnt0), 0);
      tick(); tick();

      // early release during a 16-beat burst
      apply_reset();
      req0 = 1;
      tick();
      issue(0, 1'b1, 25'h1000, 17'd16);
      req0 = 0;
      flash_rd(0, 16, 1'b0, 1'b1);
      chk("t5_release", int'(gnt0), 0);
      tick(); tick();

      // reset on the 8th beat of a burst
      apply_reset();
      req0 = 1;
      tick();
      issue(0, 1'b1, 25'h2000, 17'd16);
      gap();
      for (int i = 0; i < 7; i++) begin
         m_rd_valid = 1;
         m_rd_data  = beat(0, i);
         push_rsp(0, 2'd1, beat(0, i));
         tick();
      end
      m_rd_valid = 1;
      m_rd_data  = beat(0, 7);
      @(negedge clk);
      #1 rst = 1;
      #1 chk_zero("rst_mid_burst");
      m_rd_valid = 0;
      m_rd_data  = '0;
      req0 = 0;
      req1 = 1;
      tick(); tick();
      rst = 0;
      tick();
      chk("t6_gnt1_first", int'(gnt1), 1);
      chk("t6_gnt0_low", int'(gnt0), 0);
      issue(1, 1'b0, 25'h0010, 17'h0001);
      flash_wr(1, 1'b1);
      tick(); tick(); tick();

      chk("cmd_q_drained", cmd_q.size(), 0);
      chk("rsp_q_drained", rsp_q.size(), 0);
      chk("err_q_drained", err_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule

// File: doc/flash_arb.md
# flash_arb

Two-port arbiter that shares the single flash controller command interface (register-write channel plus burst-read channel) between two requesters, e.g. the burst-read sequencer and a flash program/erase sequencer. A requester locks the controller for a whole multi-command sequence (configuration write, burst read, restore write) so sequences never interleave. Grants alternate round-robin under contention. Command and response paths are registered, and out-of-protocol commands are dropped and flagged.

## Interface
- No parameters. Widths are fixed by the flash controller: address 25, data 16, length 17.
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- reqN  in  1  (N=0,1) lock request. Held high for the full sequence.
- gntN  out  1  grant. The port may issue commands only while this is high.
- errN  out  1  one-cycle pulse: command dropped (protocol violation)
- sN_wr_en / sN_wr_addr[24:0] / sN_wr_data[15:0]  in  register-write command from port N
- sN_wr_done  out  1  write completion, routed to the granted port
- sN_rd_en / sN_rd_addr[24:0] / sN_rd_length[16:0]  in  burst-read command from port N
- sN_rd_data[15:0] / sN_rd_valid / sN_rd_done  out  read response, routed to the granted port
- m_wr_en, m_wr_addr[24:0], m_wr_data[15:0]  out  to the flash controller
- m_wr_done  in  1
- m_rd_en, m_rd_addr[24:0], m_rd_length[16:0]  out  to the flash controller
- m_rd_data[15:0], m_rd_valid, m_rd_done  in

## Operation
- **States** (one-hot): IDLE, GRANT0, GRANT1, RELEASE. Reset enters IDLE with `rr_ptr=0` and `busy=0`.
- **IDLE**
  - Only one req high: go to that port's GRANT state.
  - Both high: go to GRANT[`rr_ptr`].
  - Neither high: stay in IDLE.
- **GRANTn**
  - `gntn=1`.
  - A valid command from port n is forwarded and sets `busy`.
  - `m_wr_done` or `m_rd_done` clears `busy`.
  - Exit to RELEASE when `reqn=0`, `busy=0`, and port n issues no command in that cycle.
- **RELEASE**
  - Lasts one cycle with both gnt low.
  - Sets `rr_ptr` to the other port, then goes to IDLE.
  - Result: a port that re-requests immediately loses to a waiting peer.
- **Valid command:** from the granted port, `busy=0`, and exactly one of wr_en/rd_en high.
- **Dropped commands** (errN pulses next cycle, nothing is forwarded):
  - any wr_en or rd_en from a non-granted port;
  - any command while `busy=1`;
  - wr_en and rd_en asserted together.
- **req dropped while busy:** the grant is held until the outstanding done arrives, then the block goes to RELEASE.
- **Command in the same cycle req falls:** the command is accepted and the grant is held until its done.
- **Response routing:** m_wr_done, m_rd_data, m_rd_valid and m_rd_done go to the port owning the grant at the cycle they arrive. The non-owner sees 0. A response arriving in IDLE or RELEASE is discarded.
- **Non-command cycles:** m_wr_addr, m_wr_data, m_rd_addr and m_rd_length are 0. Non-owner response outputs are 0.

## Timing
- **Reset:** every output is 0 (gnt, err, all m_* outputs, all sN_* outputs).
- **Request to grant:** req high sampled at edge k gives gnt high from cycle k+1, with no contention and the block in IDLE.
- **Command latency:** a command sampled at edge k appears on m_* for exactly one cycle, k+1. Address, data and length are registered with the enable.
- **Response latency:** m_* response sampled at edge k appears on sN_* at cycle k+1. Each registered response output follows one-for-one, so a rd_valid burst is passed through with no gaps added.
- **Release to re-grant:** the last done at edge k gives gnt low at k+1 (RELEASE), IDLE at k+2, and the next grant at k+3. Minimum of 2 dead cycles between owners.
- **Error pulse:** errN is high for one cycle, at k+1 after the offending edge k.
- **Reset mid-operation:**
  - The block returns to IDLE immediately, and any in-flight m_* pulse is cleared.
  - `busy` and `rr_ptr` are cleared.
  - The flash controller is reset by the same rst, so the outstanding done is discarded.

## Test plan
- **Single requester:**
  - Stimulus: req0 high; write 0x6407/0x0060, write 0x6407/0x0003, read addr 0x12345 length 4, write 0x8000/0x0060, write 0x8000/0x0003, each after the previous done; then drop req0.
  - Response: m_* mirrors each command one cycle later; s0 receives 4 rd_valid beats and then rd_done; gnt0 falls 1 cycle after req0 drops with busy clear.
- **Contention:**
  - Stimulus: req0 and req1 rise in the same cycle after reset.
  - Response: gnt0 first; gnt1 three cycles after port 0's final done (RELEASE, IDLE, grant); gnt0 and gnt1 never high together.
- **Round-robin:**
  - Stimulus: both reqs held continuously, 3 sequences each.
  - Response: grants alternate 0,1,0,1,0,1.
- **Violations:**
  - Stimulus: port1 pulses rd_en while port0 is granted; port0 issues wr_en while busy; port0 asserts wr_en and rd_en together.
  - Response: each gives the matching errN one-cycle pulse, no m_* activity, and no change in state or busy.
- **Early release:**
  - Stimulus: port0 drops req0 the cycle after issuing a length-16 read.
  - Response: gnt0 stays high until m_rd_done is forwarded; all 16 beats are routed to s0.
- **Reset mid-burst:**
  - Stimulus: assert rst during the 8th rd_valid beat.
  - Response: all outputs 0 in the same cycle; after rst release with req1 high, gnt1 is granted first.
